register_file16: RTL and testbench

Eight-entry, 16-bit register file for the 16-bit core, directly downstream of the pipeline/decoder. It consumes the decoder's active-low load, increment and decrement vectors and its read selects. It provides the ALU A/B operands, the memory write data and the memory address. r7 is the program counter and r6 is the link register; no register receives special treatment beyond PC reset.

---
 rtl/register_file16.sv | 105 ++++++++++
 tb/tb_register_file16.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file16.sv
// register_file16: eight BITS-wide registers (r7 = PC, r6 = link) with
// active-low per-register load/increment/decrement vectors and four
// combinational read ports.
module register_file16 #(
  parameter int             BITS     = 16,
  parameter logic [BITS-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RSTb,
  input  logic [BITS-1:0] aluOut,
  input  logic [BITS-1:0] memIn,
  input  logic [BITS-1:0] pout,
  input  logic [7:0]      LD_reg_ALUb,
  input  logic [7:0]      LD_reg_Mb,
  input  logic [7:0]      LD_reg_Pb,
  input  logic [7:0]      INCb,
  input  logic [7:0]      DECb,
  input  logic [2:0]      ALU_A_SEL,
  input  logic [2:0]      ALU_B_SEL,
  input  logic            ALU_B_from_inP_b,
  input  logic            M_ENb,
  input  logic [2:0]      M_SEL,
  input  logic [2:0]      MADDR_SEL,
  output logic [BITS-1:0] aluA,
  output logic [BITS-1:0] aluB,
  output logic [BITS-1:0] memOut,
  output logic [BITS-1:0] memAddr,
  output logic [BITS-1:0] pc
);

  localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

  logic [BITS-1:0] regs_q [8];
  logic [BITS-1:0] regs_d [8];

  // Flat 8:1 read mux; kept as a single case to stay on the short path
  // into the external ALU.
  function automatic logic [BITS-1:0] read_reg(input logic [2:0] sel,
                                               input logic [BITS-1:0] r0,
                                               input logic [BITS-1:0] r1,
                                               input logic [BITS-1:0] r2,
                                               input logic [BITS-1:0] r3,
                                               input logic [BITS-1:0] r4,
                                               input logic [BITS-1:0] r5,
                                               input logic [BITS-1:0] r6,
                                               input logic [BITS-1:0] r7);
    logic [BITS-1:0] v;
    case (sel)
      3'd0:    v = r0;
      3'd1:    v = r1;
      3'd2:    v = r2;
      3'd3:    v = r3;
      3'd4:    v = r4;
      3'd5:    v = r5;
      3'd6:    v = r6;
      default: v = r7;
    endcase
    return v;
  endfunction

  // Per-register next state: ALU load > memory load > pipeline load >
  // increment/decrement; both or neither of inc/dec means hold.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
      if (!LD_reg_ALUb[i])
        regs_d[i] = aluOut;
      else if (!LD_reg_Mb[i])
        regs_d[i] = memIn;
      else if (!LD_reg_Pb[i])
        regs_d[i] = pout;
      else if (!INCb[i] && DECb[i])
        regs_d[i] = regs_q[i] + ONE;
      else if (!DECb[i] && INCb[i])
        regs_d[i] = regs_q[i] - ONE;
    end
  end

  // Register update; synchronous reset overrides every pending update.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      for (int i = 0; i < 7; i++) regs_q[i] <= '0;
      regs_q[7] <= RESET_PC;
    end else begin
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Combinational read ports; memOut is driven low (not floated) when disabled.
  always_comb begin
    aluA    = read_reg(ALU_A_SEL, regs_q[0], regs_q[1], regs_q[2], regs_q[3],
                       regs_q[4], regs_q[5], regs_q[6], regs_q[7]);
    aluB    = ALU_B_from_inP_b
              ? read_reg(ALU_B_SEL, regs_q[0], regs_q[1], regs_q[2], regs_q[3],
                         regs_q[4], regs_q[5], regs_q[6], regs_q[7])
              : pout;
    memOut  = M_ENb ? '0
              : read_reg(M_SEL, regs_q[0], regs_q[1], regs_q[2], regs_q[3],
                         regs_q[4], regs_q[5], regs_q[6], regs_q[7]);
    memAddr = read_reg(MADDR_SEL, regs_q[0], regs_q[1], regs_q[2], regs_q[3],
                       regs_q[4], regs_q[5], regs_q[6], regs_q[7]);
    pc      = regs_q[7];
  end

endmodule

// File: tb/tb_register_file16.sv
// Testbench for register_file16: directed stimulus pushes expected port
// values into a queue; a monitor pops and compares them on the falling edge.
module tb_register_file16;

  localparam int P_PC = 0, P_ALUA = 1, P_ALUB = 2, P_MEMOUT = 3, P_MEMADDR = 4;

  typedef struct {
    int          port;
    logic [15:0] exp;
    string       name;
  } exp_t;

  logic        CLK;
  logic        RSTb;
  logic [15:0] aluOut, memIn, pout;
  logic [7:0]  LD_reg_ALUb, LD_reg_Mb, LD_reg_Pb, INCb, DECb;
  logic [2:0]  ALU_A_SEL, ALU_B_SEL, M_SEL, MADDR_SEL;
  logic        ALU_B_from_inP_b, M_ENb;
  logic [15:0] aluA, aluB, memOut, memAddr, pc;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  register_file16 #(.BITS(16), .RESET_PC(16'h0100)) dut (
    .CLK(CLK), .RSTb(RSTb), .aluOut(aluOut), .memIn(memIn), .pout(pout),
    .LD_reg_ALUb(LD_reg_ALUb), .LD_reg_Mb(LD_reg_Mb), .LD_reg_Pb(LD_reg_Pb),
    .INCb(INCb), .DECb(DECb), .ALU_A_SEL(ALU_A_SEL), .ALU_B_SEL(ALU_B_SEL),
    .ALU_B_from_inP_b(ALU_B_from_inP_b), .M_ENb(M_ENb), .M_SEL(M_SEL),
    .MADDR_SEL(MADDR_SEL), .aluA(aluA), .aluB(aluB), .memOut(memOut),
    .memAddr(memAddr), .pc(pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input int port, input logic [15:0] exp, input string name);
    exp_t e;
    e.port = port;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the selected port.
  initial begin
    exp_t        e;
    logic [15:0] got;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.port)
          P_PC:      got = pc;
          P_ALUA:    got = aluA;
          P_ALUB:    got = aluB;
          P_MEMOUT:  got = memOut;
          default:   got = memAddr;
        endcase
        total++;
        if (got !== e.exp) begin
          bad++;
          $display("FAIL %s: got %04h expected %04h", e.name, got, e.exp);
        end else begin
          $display("check %s: %04h ok", e.name, got);
        end
      end
    end
  end

  initial begin
    RSTb = 1'b0;
    aluOut = '0; memIn = '0; pout = '0;
    LD_reg_ALUb = 8'hFF; LD_reg_Mb = 8'hFF; LD_reg_Pb = 8'hFF;
    INCb = 8'hFF; DECb = 8'hFF;
    ALU_A_SEL = 3'd0; ALU_B_SEL = 3'd0; M_SEL = 3'd7; MADDR_SEL = 3'd0;
    ALU_B_from_inP_b = 1'b1; M_ENb = 1'b1;

    // Reset
    step();
    RSTb = 1'b1;
    ALU_A_SEL = 3'd7;
    chk(P_PC, 16'h0100, "reset_pc");
    chk(P_ALUA, 16'h0100, "reset_aluA_sel7");
    chk(P_MEMOUT, 16'h0000, "reset_memout_disabled");
    step();
    for (int i = 0; i < 7; i++) begin
      ALU_A_SEL = 3'(i);
      chk(P_ALUA, 16'h0000, $sformatf("reset_r%0d", i));
      step();
    end

    // Fetch increment three times
    INCb = 8'h7F;
    step(); step(); step();
    INCb = 8'hFF;
    chk(P_PC, 16'h0103, "pc_inc3");
    step();

    // Decrement wrap on r6
    DECb = 8'hBF;
    step();
    DECb = 8'hFF;
    ALU_A_SEL = 3'd6;
    chk(P_ALUA, 16'hFFFF, "r6_dec_wrap");
    step();
    INCb = 8'hBF;
    step();
    INCb = 8'hFF;
    chk(P_ALUA, 16'h0000, "r6_inc_wrap");
    step();

    // Branch: load beats increment
    LD_reg_Pb = 8'h7F; INCb = 8'h7F; pout = 16'h0042;
    chk(P_PC, 16'h0103, "pc_before_branch");
    step();
    LD_reg_Pb = 8'hFF; INCb = 8'hFF;
    chk(P_PC, 16'h0042, "pc_branch");
    step();

    // Load priority on r3
    aluOut = 16'h1111; memIn = 16'h2222; pout = 16'h3333;
    LD_reg_ALUb = 8'hF7; LD_reg_Mb = 8'hF7; LD_reg_Pb = 8'hF7;
    step();
    LD_reg_ALUb = 8'hFF;
    ALU_A_SEL = 3'd3;
    chk(P_ALUA, 16'h1111, "r3_alu_prio");
    step();
    LD_reg_Mb = 8'hFF;
    chk(P_ALUA, 16'h2222, "r3_mem_prio");
    step();
    LD_reg_Pb = 8'hFF;
    chk(P_ALUA, 16'h3333, "r3_pout_load");
    step();

    // Inc and dec together hold
    aluOut = 16'h7FFF; LD_reg_ALUb = 8'hFB;
    step();
    LD_reg_ALUb = 8'hFF; INCb = 8'hFB; DECb = 8'hFB;
    step();
    DECb = 8'hFF;
    ALU_A_SEL = 3'd2;
    chk(P_ALUA, 16'h7FFF, "r2_incdec_hold");
    step();
    INCb = 8'hFF;
    chk(P_ALUA, 16'h8000, "r2_inc");
    step();

    // memOut enable
    memIn = 16'hBEEF; LD_reg_Mb = 8'hDF;
    step();
    LD_reg_Mb = 8'hFF; M_SEL = 3'd5; M_ENb = 1'b1;
    chk(P_MEMOUT, 16'h0000, "memout_disabled");
    step();
    M_ENb = 1'b0; MADDR_SEL = 3'd5;
    chk(P_MEMOUT, 16'hBEEF, "memout_enabled");
    chk(P_MEMADDR, 16'hBEEF, "memaddr_r5");
    step();
    M_ENb = 1'b1;

    // aluB source select
    ALU_B_from_inP_b = 1'b0; pout = 16'h000A; ALU_B_SEL = 3'd5;
    chk(P_ALUB, 16'h000A, "aluB_pout");
    step();
    ALU_B_from_inP_b = 1'b1;
    chk(P_ALUB, 16'hBEEF, "aluB_r5");
    step();

    // No write-through on r4
    aluOut = 16'h1234; LD_reg_ALUb = 8'hEF; ALU_A_SEL = 3'd4;
    chk(P_ALUA, 16'h0000, "r4_old_value");
    step();
    LD_reg_ALUb = 8'hFF;
    chk(P_ALUA, 16'h1234, "r4_new_value");
    step();

    // Reset mid-operation discards loads
    aluOut = 16'h5555; LD_reg_ALUb = 8'h00; INCb = 8'h00; RSTb = 1'b0;
    step();
    RSTb = 1'b1; LD_reg_ALUb = 8'hFF; INCb = 8'hFF; ALU_B_SEL = 3'd7;
    chk(P_ALUA, 16'h0000, "midreset_r4");
    chk(P_PC, 16'h0100, "midreset_pc");
    chk(P_ALUB, 16'h0100, "midreset_aluB_sel7");
    step();

    // Same source into two registers
    pout = 16'hABCD; LD_reg_Pb = 8'hFC;
    step();
    LD_reg_Pb = 8'hFF; ALU_A_SEL = 3'd0; ALU_B_SEL = 3'd1;
    chk(P_ALUA, 16'hABCD, "multi_load_r0");
    chk(P_ALUB, 16'hABCD, "multi_load_r1");
    step();

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge CLK);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
